// File: rtl/probe_mux_rr.sv
// probe_mux_rr: round-robin merge of NUM_PORTS child probe streams onto one registered up-link word.
// Locked multi-word messages are compiled in when PROBE_MUX_LOCK_EN is defined.
module probe_mux_rr #(
    parameter int NUM_PORTS = 4,
    parameter int WIDTH     = 32,
    localparam int IDXW     = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                       UCLK,
    input  logic                       URST,
    input  logic [NUM_PORTS*WIDTH-1:0] DATAUP_IN,
    input  logic [NUM_PORTS-1:0]       DATAVALID_IN,
    input  logic [NUM_PORTS-1:0]       DELAY_IN,
    input  logic [NUM_PORTS-1:0]       LOCK_IN,
    output logic [NUM_PORTS-1:0]       ACK_OUT,
    output logic [WIDTH-1:0]           DATAUP,
    output logic                       DATAVALID,
    output logic [IDXW-1:0]            SRC,
    output logic                       DELAY,
    input  logic                       ACK
);

    localparam logic [IDXW:0] NP  = NUM_PORTS[IDXW:0];
    localparam logic [IDXW:0] ONE = {{IDXW{1'b0}}, 1'b1};

    logic                   r_dv;
    logic [WIDTH-1:0]       r_data;
    logic [IDXW-1:0]        r_src;
    logic [IDXW-1:0]        r_ptr;
    logic                   r_locked;
    logic [IDXW-1:0]        r_lock_port;

    logic                   w_adv;
    logic                   w_any;
    logic                   w_lock_hit;
    logic [NUM_PORTS-1:0]   w_lock_oh;
    logic [NUM_PORTS-1:0]   w_elig;
    logic [NUM_PORTS-1:0]   w_gnt_oh;
    logic [2*NUM_PORTS-1:0] w_rot2;
    logic [IDXW-1:0]        w_off;
    logic [IDXW:0]          w_sum;
    logic [IDXW:0]          w_sum_wr;
    logic [IDXW-1:0]        w_gnt;
    logic [IDXW:0]          w_inc;
    logic [IDXW-1:0]        w_gnt_inc;
    logic [WIDTH-1:0]       w_word;

    // Reset gates the advance so no child sees an acknowledge while the mux is held in reset.
    assign w_adv     = ~URST & (ACK | ~r_dv);
    assign w_lock_oh = NUM_PORTS'(1) << r_lock_port;
    assign w_elig    = r_locked ? (DATAVALID_IN & w_lock_oh) : DATAVALID_IN;
    assign w_any     = |w_elig;

    // Rotating by P puts the highest-priority port at bit 0; the lowest set bit is the offset.
    assign w_rot2 = {w_elig, w_elig} >> r_ptr;

    always_comb begin
        w_off = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (w_rot2[k]) w_off = IDXW'(k);
        end
    end

    assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_sum_wr  = (w_sum >= NP) ? (w_sum - NP) : w_sum;
    assign w_gnt     = w_sum_wr[IDXW-1:0];
    assign w_inc     = {1'b0, w_gnt} + ONE;
    assign w_gnt_inc = (w_inc == NP) ? '0 : w_inc[IDXW-1:0];
    assign w_gnt_oh  = NUM_PORTS'(1) << w_gnt;

    always_comb begin
        w_word = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (w_gnt == IDXW'(k)) w_word = DATAUP_IN[k*WIDTH +: WIDTH];
        end
    end

`ifdef PROBE_MUX_LOCK_EN
    assign w_lock_hit = |(LOCK_IN & w_gnt_oh);
`else
    logic w_unused_lock;
    assign w_unused_lock = ^LOCK_IN;
    assign w_lock_hit    = 1'b0;
`endif

    assign ACK_OUT = (w_adv & w_any) ? w_gnt_oh : '0;

    always_ff @(posedge UCLK or posedge URST) begin
        if (URST) begin
            r_dv        <= 1'b0;
            r_data      <= '0;
            r_src       <= '0;
            r_ptr       <= '0;
            r_locked    <= 1'b0;
            r_lock_port <= '0;
        end else if (w_adv) begin
            if (w_any) begin
                r_dv   <= 1'b1;
                r_data <= w_word;
                r_src  <= w_gnt;
                // Mid-message words keep P still; the closing word moves P past the locked port.
                if (!r_locked || !w_lock_hit) r_ptr <= w_gnt_inc;
`ifdef PROBE_MUX_LOCK_EN
                r_locked <= w_lock_hit;
                if (w_lock_hit) r_lock_port <= w_gnt;
`endif
            end else begin
                r_dv <= 1'b0;
            end
        end
    end

    assign DATAUP    = r_data;
    assign DATAVALID = r_dv;
    assign SRC       = r_src;
    assign DELAY     = |DELAY_IN | r_dv;

endmodule
